// File: rtl/spi_reg_slave.sv
// SPI mode-3 register slave: 15 read/write byte registers plus a read-only ID byte.
// All SPI pins are oversampled on aclk; frames are one command byte then one data byte.
module spi_reg_slave #(
  parameter logic [7:0] ID_VALUE  = 8'hA5,
  parameter logic [7:0] RST_VALUE = 8'h00
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         spi_cs,
  input  logic         spi_sclk,
  input  logic         spi_mosi,
  output logic         spi_miso,
  output logic         spi_miso_oe,
  output logic [119:0] reg_out,
  output logic         wr_strb,
  output logic [3:0]   wr_addr,
  output logic [7:0]   wr_data
);

  localparam int unsigned NREG = 15;
  localparam logic [3:0]  ID_ADDR = 4'hF;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] RDATA = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic       cs_s1, cs_q, cs_d;
  logic       sclk_s1, sclk_q, sclk_d;
  logic       mosi_s1, mosi_q;
  logic [1:0] settle;
  logic       armed;

  logic [2:0] state, state_nxt;
  logic [3:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] miso_sr;
  logic       skip_fall;
  logic [3:0] cmd_addr;

  logic       cs_fall, cs_rise, rise, fall;
  logic       in_frame, last_cmd_bit, last_data_bit, preload, commit;
  logic [3:0] addr_in;
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;

  // Pin synchronizers, idle-high, plus a delayed copy of sclk and cs for edge detection
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cs_s1   <= 1'b1;
      cs_q    <= 1'b1;
      cs_d    <= 1'b1;
      sclk_s1 <= 1'b1;
      sclk_q  <= 1'b1;
      sclk_d  <= 1'b1;
      mosi_s1 <= 1'b1;
      mosi_q  <= 1'b1;
    end else begin
      cs_s1   <= spi_cs;
      cs_q    <= cs_s1;
      cs_d    <= cs_q;
      sclk_s1 <= spi_sclk;
      sclk_q  <= sclk_s1;
      sclk_d  <= sclk_q;
      mosi_s1 <= spi_mosi;
      mosi_q  <= mosi_s1;
    end
  end

  // After reset the synchronizers hold a fake idle level; only arm once real CS-high is seen
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && cs_q) armed <= 1'b1;
    end
  end

  assign cs_fall       = armed && cs_d && !cs_q;
  assign cs_rise       = !cs_d && cs_q;
  assign rise          = !cs_q && sclk_q && !sclk_d;
  assign fall          = !cs_q && !sclk_q && sclk_d;
  assign in_frame      = (state == CMD) || (state == WDATA) || (state == RDATA);
  assign last_cmd_bit  = (state == CMD) && rise && (bit_cnt == 4'd7);
  assign last_data_bit = ((state == WDATA) || (state == RDATA)) && rise && (bit_cnt == 4'd15);
  assign preload       = last_cmd_bit && shift_reg[6];
  assign commit        = (state == WDATA) && last_data_bit && (cmd_addr != ID_ADDR);
  assign addr_in       = {shift_reg[2:0], mosi_q};
  assign rx_byte       = {shift_reg[6:0], mosi_q};

  // Read mux for the preload, addressed by the command byte as it completes
  always_comb begin
    rd_byte = ID_VALUE;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (addr_in == 4'(i)) rd_byte = reg_out[8*i +: 8];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:          if (cs_fall) state_nxt = CMD;
      CMD:           if (last_cmd_bit) state_nxt = shift_reg[6] ? RDATA : WDATA;
      WDATA, RDATA:  if (last_data_bit) state_nxt = DONE;
      DONE:          state_nxt = DONE;
      default:       state_nxt = IDLE;
    endcase
    if (cs_rise) state_nxt = IDLE;
  end

  // Frame datapath: bit counter, receive shift, register writes and MISO shift
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bit_cnt     <= 4'd0;
      shift_reg   <= 8'd0;
      miso_sr     <= 8'd0;
      skip_fall   <= 1'b0;
      cmd_addr    <= 4'd0;
      reg_out     <= {NREG{RST_VALUE}};
      wr_strb     <= 1'b0;
      wr_addr     <= 4'd0;
      wr_data     <= 8'd0;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
    end else begin
      wr_strb     <= 1'b0;
      spi_miso_oe <= !cs_q;

      if (state == IDLE && cs_fall) begin
        bit_cnt   <= 4'd0;
        shift_reg <= 8'd0;
        miso_sr   <= 8'd0;
        skip_fall <= 1'b0;
        cmd_addr  <= 4'd0;
      end else if (in_frame && rise) begin
        bit_cnt   <= bit_cnt + 4'd1;
        shift_reg <= rx_byte;
      end

      if (last_cmd_bit) cmd_addr <= addr_in;

      if (commit) begin
        wr_strb <= 1'b1;
        wr_addr <= cmd_addr;
        wr_data <= rx_byte;
        for (int unsigned i = 0; i < NREG; i++) begin
          if (cmd_addr == 4'(i)) reg_out[8*i +: 8] <= rx_byte;
        end
      end

      // The first fall after preload keeps bit 7 so the master's first data rise sees it
      if (preload) begin
        miso_sr   <= rd_byte;
        spi_miso  <= rd_byte[7];
        skip_fall <= 1'b1;
      end else if (state_nxt != RDATA) begin
        spi_miso <= 1'b1;
      end else if (fall) begin
        if (skip_fall) begin
          skip_fall <= 1'b0;
        end else begin
          miso_sr  <= {miso_sr[6:0], 1'b0};
          spi_miso <= miso_sr[6];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: drives mode-3 SPI frames at several sclk rates and
// checks registers, write strobes and MISO read data against a small register model.
module tb_spi_reg_slave;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         spi_cs;
  logic         spi_sclk;
  logic         spi_mosi;
  logic         spi_miso;
  logic         spi_miso_oe;
  logic [119:0] reg_out;
  logic         wr_strb;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;

  int n_chk = 0;
  int n_bad = 0;
  int half  = 4;
  int ph    = 1;

  int         strb_cnt = 0;
  logic [3:0] last_addr;
  logic [7:0] last_data;
  logic [7:0] last_regbyte;

  logic [7:0]   exp_reg [15];
  logic [119:0] exp_flat;
  logic [7:0]   rd;

  spi_reg_slave #(.ID_VALUE(8'hA5), .RST_VALUE(8'h00)) dut (
    .aclk(aclk), .aresetn(aresetn), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_out(reg_out), .wr_strb(wr_strb), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 aclk = ~aclk;

  // Strobe monitor, sampled away from the active edge
  always @(negedge aclk) begin
    if (wr_strb) begin
      strb_cnt  = strb_cnt + 1;
      last_addr = wr_addr;
      last_data = wr_data;
      last_regbyte = (wr_addr < 4'hF) ? reg_out[8*wr_addr +: 8] : 8'hxx;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (half=%0d)", tag, got, exp, half);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge aclk);
    #(ph);
  endtask

  task automatic new_phase();
    @(posedge aclk);
    ph = $urandom_range(1, 9);
    #(ph);
  endtask

  function automatic logic [119:0] flat_model();
    logic [119:0] f;
    for (int i = 0; i < 15; i++) f[8*i +: 8] = exp_reg[i];
    return f;
  endfunction

  // Clock nbits mode-3 bits; MOSI changes on fall, MISO sampled just before each data-phase rise
  task automatic send_bits(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                           output logic [7:0] r);
    logic [15:0] w;
    w = {b0, b1};
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b0;
      spi_mosi = (i < 16) ? w[15-i] : 1'b1;
      wait_cyc(half);
      if (i >= 8 && i < 16) r = {r[6:0], spi_miso};
      spi_sclk = 1'b1;
      wait_cyc(half);
    end
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                       output logic [7:0] r);
    new_phase();
    spi_cs = 1'b0;
    wait_cyc(6);
    send_bits(b0, b1, nbits, r);
    wait_cyc(half);
    spi_cs = 1'b1;
    spi_mosi = 1'b1;
    wait_cyc(8);
  endtask

  task automatic do_reset();
    new_phase();
    aresetn = 1'b0;
    wait_cyc(3);
    aresetn = 1'b1;
    wait_cyc(6);
    for (int i = 0; i < 15; i++) exp_reg[i] = 8'h00;
  endtask

  initial begin
    aresetn  = 1'b0;
    spi_cs   = 1'b1;
    spi_sclk = 1'b1;
    spi_mosi = 1'b1;
    for (int i = 0; i < 15; i++) exp_reg[i] = 8'h00;
    wait_cyc(4);
    chk("rst_miso", 128'(spi_miso), 128'(1'b1));
    chk("rst_oe", 128'(spi_miso_oe), 128'(1'b0));
    chk("rst_strb", 128'(wr_strb), 128'(1'b0));
    chk("rst_regs", 128'(reg_out), 128'(0));

    for (int h = 0; h < 3; h++) begin
      half = (h == 0) ? 4 : (h == 1) ? 5 : 16;
      do_reset();

      // Write 0x5A to reg 3
      strb_cnt = 0;
      frame(8'h03, 8'h5A, 16, rd);
      exp_reg[3] = 8'h5A;
      chk("wr_strb_cnt", 128'(strb_cnt), 128'(1));
      chk("wr_addr", 128'(last_addr), 128'(4'h3));
      chk("wr_data", 128'(last_data), 128'(8'h5A));
      chk("wr_reg_same_cycle", 128'(last_regbyte), 128'(8'h5A));
      chk("wr_regs", 128'(reg_out), 128'(flat_model()));

      // Read back reg 3, then via an aliased command (bits 6:4 ignored)
      strb_cnt = 0;
      frame(8'h83, 8'hFF, 16, rd);
      chk("rd_data", 128'(rd), 128'(8'h5A));
      frame(8'hB3, 8'h00, 16, rd);
      chk("rd_alias", 128'(rd), 128'(8'h5A));
      chk("rd_no_strb", 128'(strb_cnt), 128'(0));
      chk("rd_regs", 128'(reg_out), 128'(flat_model()));
      chk("idle_miso", 128'(spi_miso), 128'(1'b1));
      chk("idle_oe", 128'(spi_miso_oe), 128'(1'b0));

      // ID byte and read-only behaviour of 0xF
      frame(8'h8F, 8'h00, 16, rd);
      chk("id_rd", 128'(rd), 128'(8'hA5));
      strb_cnt = 0;
      frame(8'h0F, 8'h11, 16, rd);
      chk("id_wr_no_strb", 128'(strb_cnt), 128'(0));
      chk("id_wr_regs", 128'(reg_out), 128'(flat_model()));
      frame(8'h8F, 8'h00, 16, rd);
      chk("id_rd_again", 128'(rd), 128'(8'hA5));

      // Abort after 12 bits, then a full frame
      strb_cnt = 0;
      frame(8'h05, 8'hC3, 12, rd);
      chk("abort_no_strb", 128'(strb_cnt), 128'(0));
      chk("abort_regs", 128'(reg_out), 128'(flat_model()));
      frame(8'h05, 8'hC3, 16, rd);
      exp_reg[5] = 8'hC3;
      chk("after_abort_strb", 128'(strb_cnt), 128'(1));
      chk("after_abort_regs", 128'(reg_out), 128'(flat_model()));

      // Reset after 10 bits of a write frame
      strb_cnt = 0;
      new_phase();
      spi_cs = 1'b0;
      wait_cyc(6);
      send_bits(8'h07, 8'h99, 10, rd);
      aresetn = 1'b0;
      wait_cyc(3);
      for (int i = 0; i < 15; i++) exp_reg[i] = 8'h00;
      chk("midrst_regs", 128'(reg_out), 128'(0));
      chk("midrst_miso", 128'(spi_miso), 128'(1'b1));
      chk("midrst_oe", 128'(spi_miso_oe), 128'(1'b0));
      chk("midrst_wr", 128'({wr_strb, wr_addr, wr_data}), 128'(0));
      aresetn = 1'b1;
      wait_cyc(6);
      // CS still low from before reset: the slave must ignore this frame
      send_bits(8'h07, 8'h99, 16, rd);
      wait_cyc(half);
      spi_cs = 1'b1;
      wait_cyc(8);
      chk("postrst_ignored", 128'(strb_cnt), 128'(0));
      chk("postrst_regs", 128'(reg_out), 128'(flat_model()));
      frame(8'h07, 8'h99, 16, rd);
      exp_reg[7] = 8'h99;
      chk("postrst_strb", 128'(strb_cnt), 128'(1));
      chk("postrst_data", 128'(last_data), 128'(8'h99));
      chk("postrst_regs2", 128'(reg_out), 128'(flat_model()));

      // 24 sclk pulses: only the first 16 bits count
      strb_cnt = 0;
      frame(8'h0A, 8'h3C, 24, rd);
      exp_reg[10] = 8'h3C;
      chk("extra_strb", 128'(strb_cnt), 128'(1));
      chk("extra_regs", 128'(reg_out), 128'(flat_model()));
      frame(8'h8A, 8'h00, 24, rd);
      chk("extra_rd", 128'(rd), 128'(8'h3C));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
